// File: rtl/sram22_ctrl_pkg.sv
// sram22_ctrl_pkg: shared macro geometry and controller state encoding
package sram22_ctrl_pkg;
    localparam int ADDR_WIDTH  = 11;
    localparam int DATA_WIDTH  = 8;
    localparam int WMASK_WIDTH = 8;
    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/sram22_rsp_fifo.sv
// sram22_rsp_fifo: small synchronous FIFO holding captured read data; any depth >= 2
module sram22_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int DW    = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
    assign head = mem[rd_ptr];
    // The upstream credit rule guarantees these never fire
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
        end
    end
endmodule

// File: rtl/sram22_2048x8_ctrl.sv
// sram22_2048x8_ctrl: valid/ready front-end for the sram22 2048x8 macro with
// optional post-reset zero-fill and a credit-managed read response FIFO
module sram22_2048x8_ctrl
    import sram22_ctrl_pkg::*;
#(
    parameter int RSP_DEPTH = 3,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [DATA_WIDTH-1:0]  req_din,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic                   init_done,
    output logic                   sram_rstb,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int UW = CW + 1;
    state_t state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic inflight, accept, pop, in_init;
    logic [CW-1:0] occ;
    logic [UW-1:0] used;
    // Credits count both queued data and the read still inside the macro
    assign used      = {1'b0, occ} + UW'(inflight);
    assign req_ready = !rst && state == RUN && used < UW'(RSP_DEPTH);
    assign accept    = req_valid && req_ready;
    assign in_init   = state == INIT;
    assign init_done = state == RUN;
    assign rsp_valid = occ != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign sram_rstb = !rst;
    assign sram_ce    = in_init || accept;
    assign sram_we    = in_init || (accept && req_we);
    assign sram_wmask = in_init ? '1 : accept ? req_wmask : '0;
    assign sram_addr  = in_init ? init_cnt : accept ? req_addr : '0;
    assign sram_din   = accept ? req_din : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT_ZERO ? INIT : RUN;
            init_cnt <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept && !req_we;
            if (in_init) begin
                init_cnt <= init_cnt + ADDR_WIDTH'(1);
                if (init_cnt == '1) state <= RUN;
            end
        end
    end
    sram22_rsp_fifo #(.DEPTH(RSP_DEPTH), .DW(DATA_WIDTH), .CW(CW)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  (sram_dout),
        .pop  (pop),
        .count(occ),
        .head (rsp_data)
    );
endmodule

// File: tb/tb_sram22_2048x8_ctrl.sv
// tb_sram22_2048x8_ctrl: directed scoreboard bench with a behavioural sram22 macro model
module tb_sram22_2048x8_ctrl;
    logic clk = 1'b0;
    logic rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, init_done;
    logic sram_rstb, sram_ce, sram_we;
    logic [10:0] req_addr, sram_addr;
    logic [7:0] req_wmask, req_din, rsp_data, sram_wmask, sram_din, sram_dout;
    logic [7:0] mem [2048];
    logic [7:0] q[$];
    int pop_cyc[$];
    int checks = 0, fails = 0, cyc = 0, seen, t0;
    logic hold_v = 1'b0;
    logic [7:0] hold_d, e;
    logic [7:0] bp [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram22_2048x8_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_din(req_din), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .init_done(init_done), .sram_rstb(sram_rstb),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always @(posedge clk) begin
        if (sram_rstb && sram_ce) begin
            if (sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_din & sram_wmask);
            else sram_dout <= mem[sram_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (hold_v && rsp_valid) chk("rsp_hold", rsp_data, hold_d);
        hold_v = rsp_valid && !rsp_ready && !rst;
        hold_d = rsp_data;
        if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rsp_data", rsp_data, e);
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic req(input logic we, input logic [10:0] a, input logic [7:0] m,
                       input logic [7:0] d, input logic [7:0] x);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wmask = m; req_din = d;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", n < 50, 1);
        chk("pass_through", {sram_ce, sram_we, sram_addr, sram_wmask, sram_din}, {1'b1, we, a, m, d});
        if (!we) q.push_back(x);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", n < 100, 1);
        @(posedge clk); #1;
    endtask

    task automatic sweep(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!(sram_ce && sram_we && sram_wmask == 8'hFF && sram_din == 8'h00 && sram_addr == 11'(i)
                  && !init_done && !req_ready && !rsp_valid && sram_rstb)) bad++;
        end
        chk("sweep", bad, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0; req_din = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rstb", sram_rstb, 0);
        chk("rst_valid", rsp_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        sweep(2048);
        @(negedge clk);
        chk("init_done", init_done, 1);
        chk("run_ready", req_ready, 1);
        @(posedge clk); #1;
        req(1'b0, 11'h7FF, 8'h00, 8'h00, 8'h00);
        drain();
        req(1'b1, 11'h123, 8'hFF, 8'hA5, 8'h00);
        req(1'b0, 11'h123, 8'h00, 8'h00, 8'hA5);
        @(negedge clk); chk("lat_n1", rsp_valid, 0);
        @(negedge clk); chk("lat_n2", rsp_valid, 1);
        drain();
        req(1'b1, 11'h123, 8'h0F, 8'h5A, 8'h00);
        req(1'b0, 11'h123, 8'h00, 8'h00, 8'hAA);
        req(1'b1, 11'h123, 8'h00, 8'hFF, 8'h00);
        req(1'b0, 11'h123, 8'h00, 8'h00, 8'hAA);
        drain();
        for (int i = 0; i < 5; i++) req(1'b1, 11'h010 + 11'(i), 8'hFF, bp[i], 8'h00);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) req(1'b0, 11'h010 + 11'(i), 8'h00, 8'h00, bp[i]);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h013;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(req_ready);
        end
        chk("stall_ready", seen, 0);
        chk("stall_head", rsp_data, 8'h11);
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b1;
        req(1'b0, 11'h013, 8'h00, 8'h00, bp[3]);
        req(1'b0, 11'h014, 8'h00, 8'h00, bp[4]);
        drain();
        for (int i = 0; i < 16; i++) req(1'b1, 11'h200 + 11'(i), 8'hFF, 8'(i * 37 + 5), 8'h00);
        pop_cyc.delete();
        t0 = cyc;
        for (int i = 0; i < 16; i++) req(1'b0, 11'h200 + 11'(i), 8'h00, 8'h00, 8'(i * 37 + 5));
        chk("b2b_cycles", cyc - t0, 16);
        drain();
        chk("b2b_pops", pop_cyc.size(), 16);
        if (pop_cyc.size() == 16) chk("b2b_span", pop_cyc[15] - pop_cyc[0], 15);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) req(1'b0, 11'h200 + 11'(i), 8'h00, 8'h00, 8'(i * 37 + 5));
        rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_valid", rsp_valid, 1);
        chk("rst_run_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0; q.delete(); rsp_ready = 1'b1;
        sweep(100);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("init_rst_addr", sram_addr, 11'd100);
        @(posedge clk); #1 rst = 1'b0;
        sweep(2048);
        @(negedge clk);
        chk("init_done2", init_done, 1);
        @(posedge clk); #1;
        req(1'b0, 11'h123, 8'h00, 8'h00, 8'h00);
        req(1'b0, 11'h200, 8'h00, 8'h00, 8'h00);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
